// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key length encoding, Nk/Nr lookups,
// round constants and the forward S-box.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2,
    KEY_BAD = 2'd3
  } key_len_e;

  localparam logic [3:0]  NK_LUT       [4] = '{4'd4, 4'd6, 4'd8, 4'd0};
  localparam logic [3:0]  NR_LUT       [4] = '{4'd10, 4'd12, 4'd14, 4'd0};
  localparam int unsigned KEY_BITS_LUT [4] = '{128, 192, 256, 0};

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Row n holds S(n0)..S(nf); entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX_FLAT >> {~b, 3'b000};
    return t[7:0];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o[31:24] = sbox(word_i[31:24]);
  assign word_o[23:16] = sbox(word_i[23:16]);
  assign word_o[15:8]  = sbox(word_i[15:8]);
  assign word_o[7:0]   = sbox(word_i[7:0]);

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one word per cycle, with independent
// forward (encrypt) and reverse (decrypt) round-key read ports.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         key_load,
  output logic         busy,
  output logic         sched_valid,
  output logic         key_err,
  output logic [3:0]   num_rounds,
  input  logic         enc_start,
  input  logic         enc_next,
  output logic [127:0] enc_key,
  output logic [3:0]   enc_round,
  output logic         enc_last,
  input  logic         dec_start,
  input  logic         dec_next,
  output logic [127:0] dec_key,
  output logic [3:0]   dec_round,
  output logic         dec_last
);

  localparam int unsigned NR_MAX = (MAX_KEY_BITS >= 256) ? 14 :
                                   (MAX_KEY_BITS >= 192) ? 12 : 10;
  localparam int unsigned NW     = 4 * (NR_MAX + 1);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  state_e       state_q, state_d;
  key_len_e     klen_q, klen_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   phase_q, phase_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         sched_valid_q, sched_valid_d;
  logic         key_err_q, key_err_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   enc_round_q, enc_round_d, dec_round_q, dec_round_d;
  logic [127:0] enc_key_q, enc_key_d, dec_key_q, dec_key_d;
  logic         enc_last_q, enc_last_d, dec_last_q, dec_last_d;

  logic [31:0]  w_q [NW];

  key_len_e     kl_in;
  logic         load_bad, load_ok, gen_en, last_word;
  logic [3:0]   nk;
  logic [31:0]  prev_w, back_w, sub_in, sub_out, temp_w, new_w;

  assign kl_in    = key_len_e'(key_len);
  assign load_bad = key_load && (kl_in == KEY_BAD || KEY_BITS_LUT[kl_in] > MAX_KEY_BITS);
  assign load_ok  = key_load && !load_bad;
  assign gen_en   = (state_q == ST_EXPAND) && !load_ok;

  // phase_q tracks i mod Nk so Nk=6 needs no divider.
  assign nk        = NK_LUT[klen_q];
  assign prev_w    = w_q[idx_q - 6'd1];
  assign back_w    = w_q[idx_q - {2'b00, nk}];
  assign sub_in    = (phase_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign last_word = (idx_q == {nr_q, 2'b11});

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp_w = prev_w;
    if (phase_q == '0) begin
      temp_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (nk == 4'd8 && phase_q == 3'd4) begin
      temp_w = sub_out;
    end
  end

  assign new_w = back_w ^ temp_w;

  // Loading writes all eight key words; any beyond Nk are overwritten by expansion.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      for (int unsigned j = 0; j < 8; j++) begin
        w_q[6'(j)] <= key_in[255 - 32*j -: 32];
      end
    end else if (gen_en) begin
      w_q[idx_q] <= new_w;
    end
  end

  always_comb begin
    state_d       = state_q;
    klen_d        = klen_q;
    idx_d         = idx_q;
    phase_d       = phase_q;
    rcon_d        = rcon_q;
    sched_valid_d = sched_valid_q;
    nr_d          = nr_q;
    key_err_d     = load_bad;
    if (load_ok) begin
      state_d       = ST_EXPAND;
      klen_d        = kl_in;
      idx_d         = {2'b00, NK_LUT[kl_in]};
      phase_d       = '0;
      rcon_d        = RCON[0];
      sched_valid_d = 1'b0;
      nr_d          = NR_LUT[kl_in];
    end else if (state_q == ST_EXPAND) begin
      idx_d   = idx_q + 6'd1;
      phase_d = ({1'b0, phase_q} == nk - 4'd1) ? '0 : phase_q + 3'd1;
      if (phase_q == '0) begin
        rcon_d = xtime(rcon_q);
      end
      if (last_word) begin
        state_d       = ST_IDLE;
        sched_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    enc_round_d = enc_round_q;
    enc_key_d   = enc_key_q;
    enc_last_d  = enc_last_q;
    dec_round_d = dec_round_q;
    dec_key_d   = dec_key_q;
    dec_last_d  = dec_last_q;
    if (sched_valid_q && (enc_start || enc_next)) begin
      if (enc_start) begin
        enc_round_d = '0;
      end else begin
        enc_round_d = (enc_round_q < nr_q) ? enc_round_q + 4'd1 : nr_q;
      end
      enc_key_d  = {w_q[{enc_round_d, 2'd0}], w_q[{enc_round_d, 2'd1}],
                    w_q[{enc_round_d, 2'd2}], w_q[{enc_round_d, 2'd3}]};
      enc_last_d = (enc_round_d == nr_q);
    end
    if (sched_valid_q && (dec_start || dec_next)) begin
      if (dec_start || dec_round_q > nr_q) begin
        dec_round_d = nr_q;
      end else begin
        dec_round_d = (dec_round_q == '0) ? '0 : dec_round_q - 4'd1;
      end
      dec_key_d  = {w_q[{dec_round_d, 2'd0}], w_q[{dec_round_d, 2'd1}],
                    w_q[{dec_round_d, 2'd2}], w_q[{dec_round_d, 2'd3}]};
      dec_last_d = (dec_round_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      klen_q        <= KEY_128;
      idx_q         <= '0;
      phase_q       <= '0;
      rcon_q        <= '0;
      sched_valid_q <= 1'b0;
      key_err_q     <= 1'b0;
      nr_q          <= '0;
      enc_round_q   <= '0;
      enc_key_q     <= '0;
      enc_last_q    <= 1'b0;
      dec_round_q   <= '0;
      dec_key_q     <= '0;
      dec_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      klen_q        <= klen_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      rcon_q        <= rcon_d;
      sched_valid_q <= sched_valid_d;
      key_err_q     <= key_err_d;
      nr_q          <= nr_d;
      enc_round_q   <= enc_round_d;
      enc_key_q     <= enc_key_d;
      enc_last_q    <= enc_last_d;
      dec_round_q   <= dec_round_d;
      dec_key_q     <= dec_key_d;
      dec_last_q    <= dec_last_d;
    end
  end

  assign busy        = (state_q == ST_EXPAND);
  assign sched_valid = sched_valid_q;
  assign key_err     = key_err_q;
  assign num_rounds  = nr_q;
  assign enc_key     = enc_key_q;
  assign enc_round   = enc_round_q;
  assign enc_last    = enc_last_q;
  assign dec_key     = dec_key_q;
  assign dec_round   = dec_round_q;
  assign dec_last    = dec_last_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: arithmetic S-box / FIPS-197 expansion model
// compared every cycle, plus directed known-answer checks.
module tb_aes_key_schedule;

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         key_load, enc_start, enc_next, dec_start, dec_next;
  logic         busy, sched_valid, key_err, enc_last, dec_last;
  logic [3:0]   num_rounds, enc_round, dec_round;
  logic [127:0] enc_key, dec_key;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_key_schedule #(.MAX_KEY_BITS(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_len     (key_len),
    .key_load    (key_load),
    .busy        (busy),
    .sched_valid (sched_valid),
    .key_err     (key_err),
    .num_rounds  (num_rounds),
    .enc_start   (enc_start),
    .enc_next    (enc_next),
    .enc_key     (enc_key),
    .enc_round   (enc_round),
    .enc_last    (enc_last),
    .dec_start   (dec_start),
    .dec_next    (dec_next),
    .dec_key     (dec_key),
    .dec_round   (dec_round),
    .dec_last    (dec_last)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197 arithmetic) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_calc(w[31:24]), sbox_calc(w[23:16]), sbox_calc(w[15:8]), sbox_calc(w[7:0])};
  endfunction

  function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1919:0] r  = '0;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 60; i++) r[1919 - 32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] rk(input logic [1919:0] s, input logic [3:0] r);
    return s[1919 - 128*int'(r) -: 128];
  endfunction

  logic [1919:0] m_work, m_sched;
  int            m_left;
  logic          m_valid, m_err, m_el, m_dl;
  logic [3:0]    m_nr, m_er, m_dr;
  logic [127:0]  m_ek, m_dk;

  always @(posedge clk or posedge rst) begin : model
    logic [3:0] er, dr;
    int nk;
    if (rst) begin
      m_left <= 0; m_valid <= 1'b0; m_err <= 1'b0; m_nr <= '0;
      m_er <= '0; m_ek <= '0; m_el <= 1'b0;
      m_dr <= '0; m_dk <= '0; m_dl <= 1'b0;
    end else begin
      if (m_valid && (enc_start || enc_next)) begin
        er = enc_start ? 4'd0 : ((m_er < m_nr) ? m_er + 4'd1 : m_nr);
        m_er <= er; m_ek <= rk(m_sched, er); m_el <= (er == m_nr);
      end
      if (m_valid && (dec_start || dec_next)) begin
        dr = dec_start ? m_nr : ((m_dr == 4'd0) ? 4'd0 : m_dr - 4'd1);
        m_dr <= dr; m_dk <= rk(m_sched, dr); m_dl <= (dr == 4'd0);
      end
      m_err <= key_load && key_len == 2'd3;
      if (key_load && key_len != 2'd3) begin
        nk = 4 + 2 * int'(key_len);
        m_work  <= expand(key_in, nk);
        m_left  <= 3 * nk + 28;
        m_nr    <= 4'(nk + 6);
        m_valid <= 1'b0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_sched <= m_work;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",        busy,        m_left > 0);
      check("sched_valid", sched_valid, m_valid);
      check("key_err",     key_err,     m_err);
      check("num_rounds",  num_rounds,  m_nr);
      check("enc_key",     enc_key,     m_ek);
      check("enc_round",   enc_round,   m_er);
      check("enc_last",    enc_last,    m_el);
      check("dec_key",     dec_key,     m_dk);
      check("dec_round",   dec_round,   m_dr);
      check("dec_last",    dec_last,    m_dl);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load_key(input logic [255:0] k, input logic [1:0] l);
    @(negedge clk);
    key_in = k; key_len = l; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
  endtask

  task automatic cmd(input logic es, input logic en, input logic ds, input logic dn);
    @(negedge clk);
    enc_start = es; enc_next = en; dec_start = ds; dec_next = dn;
    @(negedge clk);
    enc_start = 1'b0; enc_next = 1'b0; dec_start = 1'b0; dec_next = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; key_in = '0; key_len = '0; key_load = 1'b0;
    enc_start = 1'b0; enc_next = 1'b0; dec_start = 1'b0; dec_next = 1'b0;
    #1 rst = 1'b1;
    chk_en = 1'b1;

    check("pin_sbox_00", sbox_calc(8'h00), 8'h63);
    check("pin_sbox_53", sbox_calc(8'h53), 8'hed);
    check("pin_rk10_128", rk(expand(K128, 4), 4'd10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("pin_rk12_192", rk(expand(K192, 6), 4'd12), 128'ha4970a331a78dc09c418c271e3a41d5d);
    check("pin_rk14_256", rk(expand(K256, 8), 4'd14), 128'h24fc79ccbf0979e9371ac23c6d68de36);

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", sched_valid, 1'b0);
    check("rst_nr", num_rounds, 4'd0);
    check("rst_dec_last", dec_last, 1'b0);
    check("rst_enc_last", enc_last, 1'b0);
    rst = 1'b0;

    // 128-bit known answer, forward walk with saturation
    load_key(K128, 2'd0);
    wait_busy(n);
    check("busy_cycles_128", 128'(n), 128'd40);
    check("valid_128", sched_valid, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("enc_r0_128", enc_key, K128[255:128]);
    repeat (10) cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("enc_r10_128", enc_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("enc_round10", enc_round, 4'd10);
    check("enc_last10", enc_last, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("enc_sat", enc_round, 4'd10);

    // 192-bit known answer via decrypt port
    load_key(K192, 2'd1);
    wait_busy(n);
    check("busy_cycles_192", 128'(n), 128'd46);
    check("nr_192", num_rounds, 4'd12);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("dec_r12_192", dec_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
    check("dec_round12", dec_round, 4'd12);

    // 256-bit reverse walk to floor
    load_key(K256, 2'd2);
    wait_busy(n);
    check("busy_cycles_256", 128'(n), 128'd52);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("dec_r14_256", dec_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    repeat (14) cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("dec_r0_256", dec_key, K256[255:128]);
    check("dec_last0", dec_last, 1'b1);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    check("dec_floor", dec_round, 4'd0);

    // restart mid-expansion, invalid length, commands while busy
    load_key(K128, 2'd0);
    repeat (10) @(negedge clk);
    load_key(K256, 2'd2);
    wait_busy(n);
    check("restart_cycles", 128'(n), 128'd52);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart_dec_r14", dec_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    load_key(K192, 2'd3);
    check("key_err_pulse", key_err, 1'b1);
    check("key_err_busy", busy, 1'b0);
    check("key_err_valid", sched_valid, 1'b1);
    check("key_err_nr", num_rounds, 4'd14);
    @(negedge clk);
    check("key_err_clear", key_err, 1'b0);
    load_key(K192, 2'd1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_start_key", enc_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("busy_next_round", enc_round, 4'd10);
    check("busy_next_last", enc_last, 1'b1);
    wait_busy(n);
    check("nr_192b", num_rounds, 4'd12);

    // start beats next; concurrent enc/dec stepping
    cmd(1'b1, 1'b1, 1'b1, 1'b0);
    check("both_enc_round", enc_round, 4'd0);
    check("both_enc_key", enc_key, K192[255:128]);
    check("both_dec_key", dec_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
    repeat (3) cmd(1'b0, 1'b1, 1'b0, 1'b1);
    check("conc_enc_round", enc_round, 4'd3);
    check("conc_dec_round", dec_round, 4'd9);

    // asynchronous reset mid-expansion
    load_key(K128, 2'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_valid", sched_valid, 1'b0);
    check("arst_err", key_err, 1'b0);
    check("arst_nr", num_rounds, 4'd0);
    check("arst_enc_key", enc_key, 128'h0);
    check("arst_enc_round", enc_round, 4'd0);
    check("arst_enc_last", enc_last, 1'b0);
    check("arst_dec_key", dec_key, 128'h0);
    check("arst_dec_round", dec_round, 4'd0);
    check("arst_dec_last", dec_last, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cmd(1'b1, 1'b0, 1'b1, 1'b0);
    check("post_rst_enc_key", enc_key, 128'h0);
    check("post_rst_dec_key", dec_key, 128'h0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", sched_valid, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
